// File: rtl/fp_addsub_pipe.sv
// Parametrised IEEE-754-style adder/subtractor: round-to-nearest-even, denormals
// flushed to zero, one operation per cycle, result five cycles after capture.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    input  logic                 arg_vld,
    output logic [EXP_W+MAN_W:0] result,
    output logic [1:0]           state,
    output logic                 res_vld
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int GW  = MAN_W + 4;
    localparam int LZW = $clog2(GW + 1);
    localparam int EW  = EXP_W + LZW + 2;

    localparam logic [1:0]    ST_OK  = 2'b00;
    localparam logic [1:0]    ST_NAN = 2'b01;
    localparam logic [1:0]    ST_INF = 2'b10;
    localparam logic [1:0]    ST_NUL = 2'b11;
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0] EZERO  = EW'(0);
    localparam logic [EW-1:0] EW_ONE = EW'(1);
    localparam logic [LZW-1:0] LZ_ONE = LZW'(1);

    typedef struct packed {
        logic         vld;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } in_t;

    typedef struct packed {
        logic             vld, nan, inf, isgn;
        logic             a_sgn;
        logic [EXP_W-1:0] a_exp;
        logic [MAN_W-1:0] a_man;
        logic             b_sgn;
        logic [EXP_W-1:0] b_exp;
        logic [MAN_W-1:0] b_man;
    } s1_t;

    typedef struct packed {
        logic             vld, nan, inf, isgn, sgn, zsgn, eop;
        logic [EXP_W-1:0] exp;
        logic [GW-1:0]    xsig;
        logic [GW-1:0]    ysig;
    } s2_t;

    typedef struct packed {
        logic             vld, nan, inf, isgn, sgn, zsgn;
        logic [EXP_W-1:0] exp;
        logic [GW:0]      sum;
    } s3_t;

    typedef struct packed {
        logic          vld, nan, inf, isgn, sgn, zsgn, zero;
        logic [EW-1:0] exp;
        logic [GW-1:0] man;
    } s4_t;

    in_t in_d, in_q;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;
    logic [W-1:0] result_d, result_q;
    logic [1:0]   state_d, state_q;
    logic         res_vld_d, res_vld_q;

    logic [EXP_W-1:0] a_e_s, b_e_s, x_e_s, y_e_s, d_s;
    logic [MAN_W-1:0] x_m_s, y_m_s;
    logic             b_sgn_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic             a_big_s, x_sgn_s, y_sgn_s, inc_s;
    logic [GW-1:0]    y_ext_s, y_mask_s;
    logic [LZW-1:0]   lz_s;
    logic [EW-1:0]    e3_s, e5_s;
    logic [MAN_W+1:0] rnd_s;
    logic [MAN_W-1:0] m5_s;

    function automatic logic [LZW-1:0] lzc(input logic [GW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = GW - 1; i >= 0; i--) begin
            if (found || v[i]) begin
                found = 1'b1;
            end else begin
                n = n + LZ_ONE;
            end
        end
        return n;
    endfunction

    // Operand capture rank
    always_comb begin
        in_d.vld = arg_vld;
        in_d.sub = sub;
        in_d.a   = a;
        in_d.b   = b;
    end

    // Stage 1: unpack, flush denormals, resolve inf/NaN outcomes as flags
    always_comb begin
        a_e_s   = in_q.a[W-2:MAN_W];
        b_e_s   = in_q.b[W-2:MAN_W];
        b_sgn_s = in_q.b[W-1] ^ in_q.sub;
        a_inf_s = (&a_e_s) && (in_q.a[MAN_W-1:0] == '0);
        a_nan_s = (&a_e_s) && (in_q.a[MAN_W-1:0] != '0);
        b_inf_s = (&b_e_s) && (in_q.b[MAN_W-1:0] == '0);
        b_nan_s = (&b_e_s) && (in_q.b[MAN_W-1:0] != '0);
        s1_d       = '0;
        s1_d.vld   = in_q.vld;
        s1_d.nan   = a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (in_q.a[W-1] ^ b_sgn_s));
        s1_d.inf   = ~(a_nan_s | b_nan_s) & (a_inf_s | b_inf_s) & ~(a_inf_s & b_inf_s & (in_q.a[W-1] ^ b_sgn_s));
        s1_d.isgn  = a_inf_s ? in_q.a[W-1] : b_sgn_s;
        s1_d.a_sgn = in_q.a[W-1];
        s1_d.a_exp = a_e_s;
        s1_d.a_man = (a_e_s == '0) ? '0 : in_q.a[MAN_W-1:0];
        s1_d.b_sgn = b_sgn_s;
        s1_d.b_exp = b_e_s;
        s1_d.b_man = (b_e_s == '0) ? '0 : in_q.b[MAN_W-1:0];
    end

    // Stage 2: larger magnitude becomes X; Y is aligned with guard/round/sticky
    always_comb begin
        a_big_s = {s1_q.a_exp, s1_q.a_man} >= {s1_q.b_exp, s1_q.b_man};
        if (a_big_s) begin
            x_sgn_s = s1_q.a_sgn; x_e_s = s1_q.a_exp; x_m_s = s1_q.a_man;
            y_sgn_s = s1_q.b_sgn; y_e_s = s1_q.b_exp; y_m_s = s1_q.b_man;
        end else begin
            x_sgn_s = s1_q.b_sgn; x_e_s = s1_q.b_exp; x_m_s = s1_q.b_man;
            y_sgn_s = s1_q.a_sgn; y_e_s = s1_q.a_exp; y_m_s = s1_q.a_man;
        end
        d_s      = x_e_s - y_e_s;
        y_ext_s  = {|y_e_s, y_m_s, 3'b000};
        y_mask_s = ~({GW{1'b1}} << d_s);
        s2_d      = '0;
        s2_d.vld  = s1_q.vld;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.isgn = s1_q.isgn;
        s2_d.sgn  = x_sgn_s;
        s2_d.zsgn = x_sgn_s & y_sgn_s;
        s2_d.eop  = x_sgn_s ^ y_sgn_s;
        s2_d.exp  = x_e_s;
        s2_d.xsig = {|x_e_s, x_m_s, 3'b000};
        s2_d.ysig = (y_ext_s >> d_s) | {{(GW-1){1'b0}}, |(y_ext_s & y_mask_s)};
    end

    // Stage 3: magnitude add or subtract; X >= Y so the difference stays non-negative
    always_comb begin
        s3_d      = '0;
        s3_d.vld  = s2_q.vld;
        s3_d.nan  = s2_q.nan;
        s3_d.inf  = s2_q.inf;
        s3_d.isgn = s2_q.isgn;
        s3_d.sgn  = s2_q.sgn;
        s3_d.zsgn = s2_q.zsgn;
        s3_d.exp  = s2_q.exp;
        if (s2_q.eop) begin
            s3_d.sum = {1'b0, s2_q.xsig} - {1'b0, s2_q.ysig};
        end else begin
            s3_d.sum = {1'b0, s2_q.xsig} + {1'b0, s2_q.ysig};
        end
    end

    // Stage 4: normalise so the hidden bit sits at the top of the mantissa field
    always_comb begin
        lz_s      = lzc(s3_q.sum[GW-1:0]);
        e3_s      = {{(EW-EXP_W){1'b0}}, s3_q.exp};
        s4_d      = '0;
        s4_d.vld  = s3_q.vld;
        s4_d.nan  = s3_q.nan;
        s4_d.inf  = s3_q.inf;
        s4_d.isgn = s3_q.isgn;
        s4_d.sgn  = s3_q.sgn;
        s4_d.zsgn = s3_q.zsgn;
        s4_d.zero = (s3_q.sum == '0);
        if (s3_q.sum[GW]) begin
            s4_d.man = {s3_q.sum[GW:2], s3_q.sum[1] | s3_q.sum[0]};
            s4_d.exp = e3_s + EW_ONE;
        end else begin
            s4_d.man = s3_q.sum[GW-1:0] << lz_s;
            s4_d.exp = e3_s - {{(EW-LZW){1'b0}}, lz_s};
        end
    end

    // Stage 5: round to nearest even, detect overflow/underflow, pack and classify
    always_comb begin
        inc_s     = s4_q.man[2] & (s4_q.man[1] | s4_q.man[0] | s4_q.man[3]);
        rnd_s     = {1'b0, s4_q.man[GW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        e5_s      = s4_q.exp + {{(EW-1){1'b0}}, rnd_s[MAN_W+1]};
        m5_s      = rnd_s[MAN_W+1] ? rnd_s[MAN_W:1] : rnd_s[MAN_W-1:0];
        result_d  = result_q;
        state_d   = state_q;
        res_vld_d = s4_q.vld;
        if (s4_q.vld) begin
            if (s4_q.nan) begin
                result_d = QNAN;
                state_d  = ST_NAN;
            end else if (s4_q.inf) begin
                result_d = {s4_q.isgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                state_d  = ST_INF;
            end else if (s4_q.zero) begin
                result_d = {s4_q.zsgn, {(W-1){1'b0}}};
                state_d  = ST_NUL;
            end else if ($signed(e5_s) >= $signed(EMAX)) begin
                result_d = {s4_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                state_d  = ST_INF;
            end else if ($signed(e5_s) <= $signed(EZERO)) begin
                result_d = {s4_q.sgn, {(W-1){1'b0}}};
                state_d  = ST_NUL;
            end else begin
                result_d = {s4_q.sgn, e5_s[EXP_W-1:0], m5_s};
                state_d  = ST_OK;
            end
        end else begin
            result_d = result_q;
            state_d  = state_q;
        end
    end

    // Pipeline ranks and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            result_q  <= '0;
            state_q   <= 2'b00;
            res_vld_q <= 1'b0;
        end else begin
            in_q      <= in_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s4_q      <= s4_d;
            result_q  <= result_d;
            state_q   <= state_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign result  = result_q;
    assign state   = state_q;
    assign res_vld = res_vld_q;

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Fully pipelined IEEE-754-style floating-point adder/subtractor with a parametrised exponent and mantissa width. It accepts one operand pair per cycle and returns the rounded sum or difference with a fixed latency of 5 cycles. Results use round-to-nearest-even, and a 2-bit status code is produced alongside each result. The block is the parametrised successor of the single-precision pipelined adder in the FPU arithmetic group, and is the adder used by the FPU datapath.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa width excluding hidden bit (≥2); word width W = 1+EXP_W+MAN_W
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-low
- a  input  W  operand A {sign, exp, man}
- b  input  W  operand B
- sub  input  1  1 = compute a−b (B sign inverted in stage 1), 0 = a+b
- arg_vld  input  1  operands valid this cycle
- result  output  W  packed result
- state  output  2  00 OK, 01 NAN, 10 INF, 11 NUL (result is ±0)
- res_vld  output  1  result/state valid this cycle

## Operation
- There is no backpressure. Every cycle, each stage's contents advance by one stage. Each stage carries its own valid bit.
- Stage 1, unpack/classify:
  - Apply the `sub` sign inversion to B.
  - Classify each operand as zero (exp=0; denormals are flushed to zero, sign kept), inf (exp all-ones, man=0), NaN (exp all-ones, man≠0), or normal.
  - Resolve the special outcome here and carry it forward as a flag:
    - Any NaN → NaN.
    - inf + inf of opposite effective signs → NaN.
    - Single inf, or two infs of equal sign → inf with that sign.
- Stage 2, swap/align:
  - Order the operands by magnitude {exp, man}; the larger becomes X.
  - Right-shift Y's significand {1, man} by the exponent difference d.
  - Keep 3 extra LSBs (guard, round, sticky). Sticky is the OR of all bits shifted past round.
  - If d ≥ MAN_W+3, Y contributes sticky only (sticky = 1 if Y is nonzero).
- Stage 3, add/sub:
  - Width is MAN_W+5 bits (carry + hidden + MAN_W + G/R/S).
  - X−Y never goes negative because of the swap. The result sign is X's sign.
- Stage 4, normalize:
  - On carry-out: shift right 1, exp+1, and fold the shifted-out bit into sticky.
  - Otherwise: count leading zeros and shift left until the hidden bit is set, with exp−lzc.
  - A zero sum is marked zero.
- Stage 5, round/pack:
  - RNE: increment when G & (R | S | LSB).
  - If the mantissa overflows on rounding, exp+1.
  - exp ≥ all-ones → ±inf, state INF.
  - exp ≤ 0 → ±0 (flush-to-zero), state NUL.
- Special results:
  - NaN = canonical quiet NaN {0, all-ones, 1, 0…0}, state NAN.
  - Exact cancellation → +0, except (−0)+(−0) → −0.
  - x ± 0 returns x exactly.
- The status is set by the final value: NUL for any ±0 result, INF for any ±inf, NAN for NaN, otherwise OK.

## Timing
- Latency: operands sampled at edge N give a result at edge N+5, so res_vld is high during cycle N+5.
- Throughput: one operation per cycle. Back-to-back arg_vld produces back-to-back res_vld.
- Outputs are registered. result, state and res_vld change only on rising clk edges.
- Reset values:
  - All valid bits, result, state and res_vld are 0.
  - Datapath registers may also reset to 0; res_vld must be 0 regardless.
- Reset mid-operation: assertion is asynchronous and clears everything immediately, so in-flight operations are discarded.
- Release takes effect at the next rising edge. The first arg_vld after release gets its result 5 cycles later.
- When arg_vld is 0, that pipeline slot carries a bubble. res_vld stays 0 for that slot, and result/state hold their last values.

## Test plan
- Default params, directed arithmetic:
  - a=0x3F800000, b=0x3F800000, sub=0 → result 0x40000000, OK, 5 cycles later.
  - Same operands with sub=1 → 0x00000000, NUL.
  - a=0x40400000, b=0x3F800000, sub=1 → 0x40000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800000 + 0x00000001 (denormal, flushed) → 0x3F800000.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, NAN.
  - 0x7FC00001 + 1.0 → 0x7FC00000, NAN.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, INF.
  - 0x00800000 − 0x00800001 (underflow) → ±0, NUL.
- Throughput/bubbles:
  - 20 consecutive random-normal pairs, then arg_vld low for 3 cycles, then 5 more pairs.
  - res_vld pattern equals the arg_vld pattern delayed by 5.
  - Every result matches the reference model bit-exactly.
- Reset mid-flight:
  - Issue 3 ops, pull rst low for 1 cycle after the second edge, release.
  - res_vld=0 and result=0 immediately.
  - No stale results emerge.
  - The next op's result appears exactly 5 cycles after it is issued.
- Parametrised instance EXP_W=5, MAN_W=10:
  - 0x3C00+0x3C00 → 0x4000.
  - 0x7BFF+0x7BFF → 0x7C00, INF.
  - 0x7C00+0xFC00 → 0x7E00, NAN.
